branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Back end of the branch-prediction loop; the BHT produces predictions, this block checks them.
- Holds in-flight predictions (pc, predicted direction, predicted target) in order in a small FIFO, from fetch until the branch resolves in MEM.
- At resolve, compares the prediction with the actual outcome, issues flush/redirect on mismatch, and drives the training strobe (pc, taken) back to BHT/BTB.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, ≥2.
- PC_W, 32, width of PC and target fields.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pred_valid  in  1  fetch pushes a predicted branch this cycle.
- pred_taken  in  1  predicted direction (BHT result).
- pred_pc  in  PC_W  branch instruction address.
- pred_target  in  PC_W  predicted target (BTB); don't-care when pred_taken=0.
- res_valid  in  1  oldest in-flight branch resolves this cycle.
- res_taken  in  1  actual direction (PCSrc).
- res_target  in  PC_W  actual computed target.
- full  out  1  FIFO holds DEPTH entries (combinational from count).
- empty  out  1  FIFO holds 0 entries.
- mispredict  out  1  registered flush request, one-cycle pulse.
- redirect_pc  out  PC_W  registered correct fetch PC; valid when mispredict=1.
- upd_valid  out  1  registered training strobe to BHT/BTB.
- upd_pc  out  PC_W  PC to train.
- upd_taken  out  1  actual outcome to train with.
- overflow  out  1  sticky: a push arrived while full and could not be accepted.
- underflow  out  1  sticky: res_valid arrived while empty.

Behaviour:
- Reset:
  - Pointers and count are 0.
  - mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, overflow and underflow are all 0.
  - empty=1, full=0.
- FIFO is strictly in order: push at tail, resolve consumes head.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- Resolve (res_valid=1, not empty):
  - Compare against head; all outputs are registered, so latency is 1 cycle.
  - miss = (head.taken != res_taken) OR (res_taken AND head.target != res_target).
  - Next cycle: upd_valid=1, upd_pc=head.pc, upd_taken=res_taken, mispredict=miss.
  - redirect_pc = res_taken ? res_target : head.pc + 4 (mod 2^PC_W).
  - Head pops.
- Mispredict flush:
  - All younger entries are wrong-path.
  - In the resolve cycle with miss=1, the whole FIFO clears next cycle (count=0, head=tail).
  - A push in that same cycle is discarded.
- Push (pred_valid=1):
  - Accepted when not full, or when full with a non-missing resolve in the same cycle (simultaneous push+pop keeps count).
  - Otherwise dropped and overflow sets.
- Simultaneous push+pop when not full: count unchanged, both pointers advance.
- res_valid when empty: no pop, no update, underflow sets, outputs stay 0.
- overflow and underflow clear only on rst.
- Idle cycles: mispredict=0, upd_valid=0; redirect_pc, upd_pc and upd_taken hold their last values.
- rst mid-operation discards all in-flight entries; no pulse is emitted in the reset cycle or the cycle after it.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs br_cnt[31:0] (resolved branches) and miss_cnt[31:0] (mispredicts).
  - Both increment in the cycle the registered strobes assert and saturate at 0xFFFF_FFFF.
  - Both reset to 0.
- Undefined: ports exist but are tied to 0; no counter flops.

Decomposition:
- Shared package bru_pkg:
  - Entry layout: pc, taken, target; entry width = 2*PC_W+1.
  - Constant PC_INC=4.
  - Helper function for the miss compare.
- One sub-module, bru_fifo:
  - Parameterised storage, pointers, count, full/empty.
  - Push, pop and clear inputs.
- The top level keeps the compare, the registered outputs, the sticky flags and the perf counters.

Test Plan:
1. Reset, then push pc=0x100 taken=1 target=0x200; resolve taken=1 target=0x200 → next cycle upd_valid=1, upd_pc=0x100, mispredict=0, empty=1.
2. Push pc=0x104 taken=0; resolve taken=1 target=0x300 → mispredict=1, redirect_pc=0x300, upd_taken=1.
3. Push 3 entries (0x10, 0x20, 0x30, all predicted taken to 0x80); resolve first with taken=0 → mispredict=1, redirect_pc=0x14, FIFO empty next cycle, later resolve raises underflow.
4. Fill all 4 entries, push a 5th → full=1, overflow=1, entry dropped; resolve all 4 in order → upd_pc sequence matches push order.
5. When full, push and non-missing resolve in the same cycle → count stays 4, overflow stays 0, new entry is resolved last.
6. With BRU_PERF_CNT_EN defined, run 10 branches with 3 misses → br_cnt=10, miss_cnt=3; assert rst mid-stream → counters, FIFO and sticky flags return to 0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: FIFO entry layout helpers,
// the sequential-PC increment and the prediction miss compare.
package bru_pkg;

  localparam int unsigned PC_INC     = 4;
  localparam int unsigned BRU_MAX_PC = 64;

  // Entry packing order (MSB..LSB): pc, taken, target; width 2*PC_W+1.
  function automatic int unsigned bru_entry_w(input int unsigned pc_w);
    return 2 * pc_w + 1;
  endfunction

  // Targets are zero-extended to BRU_MAX_PC so one helper serves any PC width.
  function automatic logic bru_is_miss(
    input logic                  pred_taken,
    input logic [BRU_MAX_PC-1:0] pred_target,
    input logic                  act_taken,
    input logic [BRU_MAX_PC-1:0] act_target
  );
    return (pred_taken != act_taken) || (act_taken && (pred_target != act_target));
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order storage for in-flight branch predictions with push/pop/clear.
// Clear wins over push and pop; a push while full is taken only alongside a pop.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign rdata_o   = mem_q[head_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s) && !clear_i;

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push_s) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-order branch predictions at resolve, raises flush/redirect and trains BHT/BTB.
// Optional perf counters br_cnt/miss_cnt are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_pc,
  input  logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic            full,
  output logic            empty,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic            upd_taken,
  output logic            overflow,
  output logic            underflow,
  output logic [31:0]     br_cnt,
  output logic [31:0]     miss_cnt
);

  localparam int EW = 2 * PC_W + 1;

  logic [EW-1:0]         head_s;
  logic [PC_W-1:0]       head_pc_s, head_target_s, redirect_d;
  logic                  head_taken_s;
  logic [BRU_MAX_PC-1:0] head_tgt_x_s, res_tgt_x_s;
  logic                  res_fire_s, miss_s, flush_s, push_s, ovf_set_s;
  logic                  mispredict_q, upd_valid_q, upd_taken_q, overflow_q, underflow_q;
  logic [PC_W-1:0]       redirect_q, upd_pc_q;

  assign head_pc_s     = head_s[EW-1:PC_W+1];
  assign head_taken_s  = head_s[PC_W];
  assign head_target_s = head_s[PC_W-1:0];

  // Miss compare against the head entry, with targets widened for the shared helper.
  always_comb begin
    head_tgt_x_s = '0;
    res_tgt_x_s  = '0;
    head_tgt_x_s[PC_W-1:0] = head_target_s;
    res_tgt_x_s[PC_W-1:0]  = res_target;
    miss_s = bru_is_miss(head_taken_s, head_tgt_x_s, res_taken, res_tgt_x_s);
  end

  assign res_fire_s = res_valid && !empty;
  assign flush_s    = res_fire_s && miss_s;
  // A full FIFO can only make room through a resolve that does not flush.
  assign push_s     = pred_valid && !flush_s && (!full || res_fire_s);
  assign ovf_set_s  = pred_valid && full && !(res_fire_s && !miss_s);
  assign redirect_d = res_taken ? res_target : (head_pc_s + PC_W'(PC_INC));

  bru_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (res_fire_s),
    .clear_i (flush_s),
    .wdata_i ({pred_pc, pred_taken, pred_target}),
    .rdata_o (head_s),
    .full_o  (full),
    .empty_o (empty)
  );

  // Registered resolve outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_taken_q  <= 1'b0;
      redirect_q   <= '0;
      upd_pc_q     <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mispredict_q <= flush_s;
      upd_valid_q  <= res_fire_s;
      if (res_fire_s) begin
        upd_pc_q    <= head_pc_s;
        upd_taken_q <= res_taken;
        redirect_q  <= redirect_d;
      end
      overflow_q  <= overflow_q || ovf_set_s;
      underflow_q <= underflow_q || (res_valid && empty);
    end
  end

  assign mispredict  = mispredict_q;
  assign upd_valid   = upd_valid_q;
  assign upd_taken   = upd_taken_q;
  assign upd_pc      = upd_pc_q;
  assign redirect_pc = redirect_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, miss_cnt_q;

  // Saturating counters that advance on the same edge the strobes assert.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (res_fire_s && (br_cnt_q != 32'hFFFF_FFFF)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (flush_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign br_cnt   = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4, PC_W=32).
module tb_branch_resolve_unit;

`ifdef BRU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        full, empty, mispredict, upd_valid, upd_taken, overflow, underflow;
  logic [31:0] redirect_pc, upd_pc, br_cnt, miss_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_miss = 0;

  branch_resolve_unit #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .full(full), .empty(empty), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .overflow(overflow), .underflow(underflow), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input string tag, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] e_pc, input logic e_miss, input logic [31:0] e_redir);
    res_valid = 1'b1; res_taken = tk; res_target = tgt;
    tick();
    res_valid = 1'b0;
    exp_br++;
    if (e_miss) exp_miss++;
    check_eq({tag, ".upd_valid"}, 64'(upd_valid), 64'd1);
    check_eq({tag, ".upd_pc"}, 64'(upd_pc), 64'(e_pc));
    check_eq({tag, ".upd_taken"}, 64'(upd_taken), 64'(tk));
    check_eq({tag, ".mispredict"}, 64'(mispredict), 64'(e_miss));
    check_eq({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e_redir));
    check_eq({tag, ".br_cnt"}, 64'(br_cnt), PERF ? 64'(exp_br) : 64'd0);
    check_eq({tag, ".miss_cnt"}, 64'(miss_cnt), PERF ? 64'(exp_miss) : 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_br = 0;
    exp_miss = 0;
    check_eq({tag, ".empty"}, 64'(empty), 64'd1);
    check_eq({tag, ".full"}, 64'(full), 64'd0);
    check_eq({tag, ".mispredict"}, 64'(mispredict), 64'd0);
    check_eq({tag, ".upd_valid"}, 64'(upd_valid), 64'd0);
    check_eq({tag, ".upd_pc"}, 64'(upd_pc), 64'd0);
    check_eq({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
    check_eq({tag, ".overflow"}, 64'(overflow), 64'd0);
    check_eq({tag, ".underflow"}, 64'(underflow), 64'd0);
    check_eq({tag, ".br_cnt"}, 64'(br_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = 32'd0; pred_target = 32'd0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = 32'd0;
    do_reset("rst0");

    // 1: correct taken prediction
    push(32'h100, 1'b1, 32'h200);
    check_eq("t1.empty_after_push", 64'(empty), 64'd0);
    resolve("t1", 1'b1, 32'h200, 32'h100, 1'b0, 32'h200);
    check_eq("t1.empty", 64'(empty), 64'd1);
    tick();
    check_eq("t1.idle_upd_valid", 64'(upd_valid), 64'd0);
    check_eq("t1.idle_upd_pc_hold", 64'(upd_pc), 64'h100);

    // 2: predicted not-taken, actually taken
    push(32'h104, 1'b0, 32'h0);
    resolve("t2", 1'b1, 32'h300, 32'h104, 1'b1, 32'h300);
    tick();
    check_eq("t2.idle_mispredict", 64'(mispredict), 64'd0);
    check_eq("t2.idle_redirect_hold", 64'(redirect_pc), 64'h300);

    // 3: flush of younger entries, push during flush discarded, then underflow
    push(32'h10, 1'b1, 32'h80);
    push(32'h20, 1'b1, 32'h80);
    push(32'h30, 1'b1, 32'h80);
    pred_valid = 1'b1; pred_pc = 32'h40; pred_taken = 1'b1; pred_target = 32'h80;
    resolve("t3", 1'b0, 32'h0, 32'h10, 1'b1, 32'h14);
    pred_valid = 1'b0;
    check_eq("t3.empty_after_flush", 64'(empty), 64'd1);
    check_eq("t3.no_overflow", 64'(overflow), 64'd0);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h500;
    tick();
    res_valid = 1'b0;
    check_eq("t3.underflow", 64'(underflow), 64'd1);
    check_eq("t3.uf_upd_valid", 64'(upd_valid), 64'd0);
    check_eq("t3.uf_mispredict", 64'(mispredict), 64'd0);
    check_eq("t3.uf_br_cnt", 64'(br_cnt), PERF ? 64'(exp_br) : 64'd0);

    // 4: fill, overflow, drain in order
    for (int i = 0; i < 4; i++) push(32'hA00 + 32'(4 * i), 1'b0, 32'h0);
    check_eq("t4.full", 64'(full), 64'd1);
    check_eq("t4.no_overflow_yet", 64'(overflow), 64'd0);
    push(32'hA10, 1'b0, 32'h0);
    check_eq("t4.overflow", 64'(overflow), 64'd1);
    check_eq("t4.still_full", 64'(full), 64'd1);
    for (int i = 0; i < 4; i++)
      resolve("t4", 1'b0, 32'h0, 32'hA00 + 32'(4 * i), 1'b0, 32'hA04 + 32'(4 * i));
    check_eq("t4.empty", 64'(empty), 64'd1);
    check_eq("t4.underflow_sticky", 64'(underflow), 64'd1);

    // 5: full with simultaneous push and non-missing resolve
    do_reset("rst5");
    for (int i = 0; i < 4; i++) push(32'hB00 + 32'(4 * i), 1'b0, 32'h0);
    pred_valid = 1'b1; pred_pc = 32'hB10; pred_taken = 1'b0; pred_target = 32'h0;
    resolve("t5.swap", 1'b0, 32'h0, 32'hB00, 1'b0, 32'hB04);
    pred_valid = 1'b0;
    check_eq("t5.full_kept", 64'(full), 64'd1);
    check_eq("t5.overflow", 64'(overflow), 64'd0);
    for (int i = 1; i < 5; i++)
      resolve("t5", 1'b0, 32'h0, 32'hB00 + 32'(4 * i), 1'b0, 32'hB04 + 32'(4 * i));
    check_eq("t5.empty", 64'(empty), 64'd1);

    // PC increment wraps; mismatched taken target is a miss
    push(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve("wrap", 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    push(32'hC00, 1'b1, 32'hD00);
    resolve("tgt", 1'b1, 32'hD04, 32'hC00, 1'b1, 32'hD04);
    push(32'hC10, 1'b1, 32'hD00);
    resolve("nt", 1'b0, 32'h0, 32'hC10, 1'b1, 32'hC14);

    // 6: reset mid-stream
    push(32'hE00, 1'b1, 32'hF00);
    push(32'hE04, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    check_eq("t6.empty_in_rst", 64'(empty), 64'd1);
    rst = 1'b0;
    tick();
    check_eq("t6.empty", 64'(empty), 64'd1);
    check_eq("t6.upd_valid", 64'(upd_valid), 64'd0);
    check_eq("t6.mispredict", 64'(mispredict), 64'd0);
    check_eq("t6.br_cnt", 64'(br_cnt), 64'd0);
    check_eq("t6.miss_cnt", 64'(miss_cnt), 64'd0);
    check_eq("t6.overflow", 64'(overflow), 64'd0);
    check_eq("t6.underflow", 64'(underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
